mux4_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for the 4:1 by DW-bit selector datapath.
- Four requesters each present DW-bit data plus a request line.
- The block grants one requester at a time, drives the 2-bit select, and emits the selected data as a registered, valid-qualified stream.
- A beat limit forces rotation so that no requester can monopolise the shared path.

---
 rtl/mux4_rr_arbiter_if.sv | 26 ++
 rtl/mux4_rr_arbiter.sv | 127 ++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mux4_rr_arbiter_if.sv
// Requester/arbiter bundle: four requests with data in, grant/select and the registered stream out.
// No backpressure: the consumer of y/y_valid must accept every beat it is offered.
interface mux4_rr_arbiter_if #(
  parameter int DW = 2
);
  logic [3:0]    req;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [DW-1:0] c;
  logic [DW-1:0] d;
  logic [3:0]    gnt;
  logic [1:0]    sel;
  logic          busy;
  logic [DW-1:0] y;
  logic          y_valid;

  modport master (
    output req, a, b, c, d,
    input  gnt, sel, busy, y, y_valid
  );

  modport slave (
    input  req, a, b, c, d,
    output gnt, sel, busy, y, y_valid
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin 4:1 arbiter with a beat limit; gnt is 1 cycle after req, y_valid is 2 cycles after req.
// A requester is stalled simply by not being granted; y_valid is dropped for any granted cycle whose req is low.
module mux4_rr_arbiter #(
  parameter int DW       = 2,
  parameter int HOLD_MAX = 4
) (
  input logic               clk,
  input logic               rst_n,
  mux4_rr_arbiter_if.slave  bus_io
);

  localparam int            CW    = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(HOLD_MAX);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state_q, state_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] y_q, y_d;
  logic          y_valid_q, y_valid_d;

  logic [DW-1:0] din [4];
  logic [3:0]    others;
  logic          at_limit;
  logic          release_c;
  logic [1:0]    win;

  assign din[0] = bus_io.a;
  assign din[1] = bus_io.b;
  assign din[2] = bus_io.c;
  assign din[3] = bus_io.d;

  // First set bit of r searching p+1, p+2, p+3, p+4 (mod 4).
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic [1:0] w;
    logic       found;
    w     = p;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = p + 2'(k);
      if (!found && r[idx]) begin
        w     = idx;
        found = 1'b1;
      end
    end
    return w;
  endfunction

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    others    = bus_io.req & ~(4'b0001 << sel_q);
    at_limit  = (HOLD_MAX != 0) && (cnt_q == LIMIT);
    release_c = !bus_io.req[sel_q] || at_limit;
    win       = 2'd0;

    case (state_q)
      IDLE: begin
        gnt_d = 4'b0000;
        if (bus_io.req != 4'b0000) begin
          win     = rr_pick(bus_io.req, ptr_q);
          gnt_d   = 4'b0001 << win;
          sel_d   = win;
          ptr_d   = win;
          cnt_d   = CW'(1);
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!release_c) begin
          // Saturate so the unlimited setting never wraps back to 0.
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        end else if (others != 4'b0000) begin
          win   = rr_pick(others, sel_q);
          gnt_d = 4'b0001 << win;
          sel_d = win;
          ptr_d = win;
          cnt_d = CW'(1);
        end else if (bus_io.req[sel_q]) begin
          cnt_d = CW'(1);
        end else begin
          gnt_d   = 4'b0000;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    y_valid_d = (state_q == GRANT) && bus_io.req[sel_q];
    y_d       = y_valid_d ? din[sel_q] : y_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= 4'b0000;
      sel_q     <= 2'd0;
      ptr_q     <= 2'd3;
      cnt_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign bus_io.gnt     = gnt_q;
  assign bus_io.sel     = sel_q;
  assign bus_io.busy    = (state_q == GRANT);
  assign bus_io.y       = y_q;
  assign bus_io.y_valid = y_valid_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter with HOLD_MAX=3; inputs change and outputs are sampled on the falling edge.
module tb_mux4_rr_arbiter;

  localparam int DW = 2;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  mux4_rr_arbiter_if #(.DW(DW)) arb_if ();

  mux4_rr_arbiter #(.DW(DW), .HOLD_MAX(3)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (arb_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    arb_if.req  = 4'b0000;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int exp_sel [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};

  initial begin
    total      = 0;
    bad        = 0;
    rst_n      = 1'b1;
    arb_if.req = 4'b0000;
    arb_if.a   = 2'b00;
    arb_if.b   = 2'b00;
    arb_if.c   = 2'b00;
    arb_if.d   = 2'b00;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_gnt",   arb_if.gnt,     4'b0000);
    chk("rst_sel",   arb_if.sel,     2'd0);
    chk("rst_busy",  arb_if.busy,    1'b0);
    chk("rst_y",     arb_if.y,       2'b00);
    chk("rst_yv",    arb_if.y_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester 2, then full drop, then 0101 picks requester 0.
    arb_if.c   = 2'b10;
    arb_if.req = 4'b0100;
    tick();
    chk("t1_gnt",  arb_if.gnt,     4'b0100);
    chk("t1_sel",  arb_if.sel,     2'd2);
    chk("t1_busy", arb_if.busy,    1'b1);
    chk("t1_yv0",  arb_if.y_valid, 1'b0);
    tick();
    chk("t1_y",    arb_if.y,       2'b10);
    chk("t1_yv1",  arb_if.y_valid, 1'b1);
    tick();
    chk("t1_yv2",  arb_if.y_valid, 1'b1);
    arb_if.req = 4'b0000;
    tick();
    chk("t5_gnt",  arb_if.gnt,     4'b0000);
    chk("t5_busy", arb_if.busy,    1'b0);
    chk("t5_sel",  arb_if.sel,     2'd2);
    chk("t5_yv",   arb_if.y_valid, 1'b0);
    chk("t5_yhold", arb_if.y,      2'b10);
    tick();
    arb_if.req = 4'b0101;
    tick();
    chk("t5_gnt2", arb_if.gnt,     4'b0001);
    chk("t5_sel2", arb_if.sel,     2'd0);

    // All four requesting: rotation every 3 beats with no gaps.
    do_reset();
    arb_if.a   = 2'd0;
    arb_if.b   = 2'd1;
    arb_if.c   = 2'd2;
    arb_if.d   = 2'd3;
    arb_if.req = 4'b1111;
    for (int k = 0; k < 13; k++) begin
      tick();
      chk($sformatf("rr_sel%0d", k), arb_if.sel, exp_sel[k]);
      chk($sformatf("rr_gnt%0d", k), arb_if.gnt, 4'b0001 << exp_sel[k]);
      if (k >= 1) begin
        chk($sformatf("rr_yv%0d", k), arb_if.y_valid, 1'b1);
        chk($sformatf("rr_y%0d", k),  arb_if.y,       exp_sel[k-1]);
      end
    end

    // Lone requester hitting the limit keeps the grant with no gap.
    do_reset();
    arb_if.a   = 2'b01;
    arb_if.req = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("solo_gnt%0d", k), arb_if.gnt, 4'b0001);
      chk($sformatf("solo_cnt%0d", k), 32'(dut.cnt_q), (k % 3) + 1);
      if (k >= 1) chk($sformatf("solo_yv%0d", k), arb_if.y_valid, 1'b1);
    end

    // Owner 1 releases as requester 3 arrives.
    do_reset();
    arb_if.b   = 2'b11;
    arb_if.d   = 2'b01;
    arb_if.req = 4'b0010;
    tick();
    chk("hand_gnt1", arb_if.gnt, 4'b0010);
    tick();
    chk("hand_yv1",  arb_if.y_valid, 1'b1);
    chk("hand_y1",   arb_if.y,       2'b11);
    arb_if.req = 4'b1000;
    tick();
    chk("hand_gnt3", arb_if.gnt,     4'b1000);
    chk("hand_sel3", arb_if.sel,     2'd3);
    chk("hand_gap",  arb_if.y_valid, 1'b0);
    tick();
    chk("hand_yv3",  arb_if.y_valid, 1'b1);
    chk("hand_y3",   arb_if.y,       2'b01);

    // Asynchronous reset in the middle of a grant.
    do_reset();
    arb_if.req = 4'b0010;
    tick();
    tick();
    chk("ar_pre_gnt", arb_if.gnt,     4'b0010);
    chk("ar_pre_yv",  arb_if.y_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_gnt",  arb_if.gnt,     4'b0000);
    chk("ar_sel",  arb_if.sel,     2'd0);
    chk("ar_y",    arb_if.y,       2'b00);
    chk("ar_yv",   arb_if.y_valid, 1'b0);
    chk("ar_busy", arb_if.busy,    1'b0);
    @(negedge clk);
    rst_n      = 1'b1;
    arb_if.req = 4'b1010;
    tick();
    chk("ar_re_gnt", arb_if.gnt, 4'b0010);
    chk("ar_re_sel", arb_if.sel, 2'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Invariants: gnt one-hot or zero, and owned by sel while busy.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!$onehot0(arb_if.gnt)) chk("inv_onehot", arb_if.gnt, 4'b0000);
      if (arb_if.busy)           chk("inv_gntsel", arb_if.gnt[arb_if.sel], 1'b1);
    end
  end

endmodule
